// File: rtl/red_cord_pkg.sv
// red_cord_pkg: shared state encoding and calibration defaults for the re-arm controller
package red_cord_pkg;
   typedef enum logic [1:0] {
      ARMED    = 2'd0,
      TRIPPED  = 2'd1,
      CLEARING = 2'd2,
      READY    = 2'd3
   } rc_state_t;
   localparam int HOLDOFF_DEFAULT    = 1000;
   localparam int CLEAR_DEFAULT      = 500;
   localparam int TRIP_CNT_W_DEFAULT = 16;
   function automatic int cnt_width(input int a, input int b);
      return $clog2((a > b ? a : b) + 1);
   endfunction
endpackage

// File: rtl/red_cord_rearm_if.sv
// red_cord_rearm_if: veto/sensor/operator inputs and power/telemetry outputs of the re-arm controller
interface red_cord_rearm_if #(parameter int TRIP_CNT_W = 16);
   logic                  veto_enable_in;
   logic                  human_presence_sensor;
   logic                  rearm_req;
   logic                  motor_power_en;
   logic                  rearm_ack;
   logic                  trip_pulse;
   logic [1:0]            state_o;
   logic [TRIP_CNT_W-1:0] trip_count;
   modport master (
      output veto_enable_in, human_presence_sensor, rearm_req,
      input  motor_power_en, rearm_ack, trip_pulse, state_o, trip_count
   );
   modport slave (
      input  veto_enable_in, human_presence_sensor, rearm_req,
      output motor_power_en, rearm_ack, trip_pulse, state_o, trip_count
   );
endinterface

// File: rtl/rc_cycle_counter.sv
// rc_cycle_counter: counts enabled cycles up to TERM-1 and parks there until cleared
module rc_cycle_counter #(
   parameter int W    = 4,
   parameter int TERM = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);
   logic [W-1:0] cnt;
   assign done = cnt == W'(TERM - 1);
   // clear wins over enable; the count never wraps past its terminal value
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !done) cnt <= cnt + 1'b1;
endmodule

// File: rtl/red_cord_rearm.sv
// red_cord_rearm: latches motor power off on any veto trip and re-arms only after holdoff, clearing and an operator edge
module red_cord_rearm
   import red_cord_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT,
   parameter int CLEAR_CYCLES   = CLEAR_DEFAULT,
   parameter int TRIP_CNT_W     = TRIP_CNT_W_DEFAULT
) (
   input logic             clk,
   input logic             rst_n,
   red_cord_rearm_if.slave bus
);
   localparam int CW = cnt_width(HOLDOFF_CYCLES, CLEAR_CYCLES);
   rc_state_t             state, state_nx;
   logic                  req_q, req_edge, clear_ok, hold_done, clr_done;
   logic                  ack_nx, trip_nx;
   logic [TRIP_CNT_W-1:0] trip_count, trip_count_nx;
   assign clear_ok = !bus.human_presence_sensor && bus.veto_enable_in;
   assign req_edge = bus.rearm_req && !req_q;
   assign bus.motor_power_en = (state == ARMED) && bus.veto_enable_in;
   assign bus.state_o = state;
   assign bus.trip_count = trip_count;
   rc_cycle_counter #(.W(CW), .TERM(HOLDOFF_CYCLES)) u_holdoff (
      .clk(clk), .rst_n(rst_n), .clr(state != TRIPPED), .en(1'b1), .done(hold_done)
   );
   rc_cycle_counter #(.W(CW), .TERM(CLEAR_CYCLES)) u_clear (
      .clk(clk), .rst_n(rst_n), .clr(state != CLEARING || !clear_ok), .en(clear_ok), .done(clr_done)
   );
   // state, request-edge history and registered outputs; reset lands in CLEARING so power needs a full pass
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= CLEARING;
         req_q         <= 1'b1;
         bus.rearm_ack <= 1'b0;
         bus.trip_pulse <= 1'b0;
         trip_count    <= '0;
      end else begin
         state         <= state_nx;
         req_q         <= bus.rearm_req;
         bus.rearm_ack <= ack_nx;
         bus.trip_pulse <= trip_nx;
         trip_count    <= trip_count_nx;
      end
   // next state; in READY a lost clearing condition outranks an operator request
   always_comb begin
      state_nx = state;
      case (state)
         ARMED:    state_nx = bus.veto_enable_in ? ARMED : TRIPPED;
         TRIPPED:  state_nx = hold_done ? CLEARING : TRIPPED;
         CLEARING: state_nx = (clear_ok && clr_done) ? READY : CLEARING;
         READY:    state_nx = !clear_ok ? CLEARING : (req_edge ? ARMED : READY);
         default:  state_nx = CLEARING;
      endcase
   end
   // next values of the registered pulses and the saturating trip counter
   always_comb begin
      ack_nx        = state == READY && clear_ok && req_edge;
      trip_nx       = state == ARMED && !bus.veto_enable_in;
      trip_count_nx = (trip_nx && trip_count != '1) ? trip_count + 1'b1 : trip_count;
   end
endmodule

// File: tb/tb_red_cord_rearm.sv
// tb_red_cord_rearm: directed checks of trip latching, holdoff/clearing dwell, re-arm edge rules, reset and saturation
module tb_red_cord_rearm;
   localparam int H = 4;
   localparam int C = 3;
   localparam int W = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   red_cord_rearm_if #(.TRIP_CNT_W(W)) bus ();
   red_cord_rearm #(.HOLDOFF_CYCLES(H), .CLEAR_CYCLES(C), .TRIP_CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      bus.veto_enable_in = 1'b1;
      bus.human_presence_sensor = 1'b0;
      bus.rearm_req = 1'b0;
      step(2);
      chk("rst_state", bus.state_o, 2);
      chk("rst_power", bus.motor_power_en, 0);
      chk("rst_ack", bus.rearm_ack, 0);
      chk("rst_trip", bus.trip_pulse, 0);
      chk("rst_count", bus.trip_count, 0);
      rst_n = 1'b1;
      // scenario 1: three clean cycles to READY, then operator edge
      step(2);
      chk("s1_clearing", bus.state_o, 2);
      step();
      chk("s1_ready", bus.state_o, 3);
      chk("s1_power_ready", bus.motor_power_en, 0);
      bus.rearm_req = 1'b1;
      step();
      chk("s1_ack", bus.rearm_ack, 1);
      chk("s1_armed", bus.state_o, 0);
      chk("s1_power", bus.motor_power_en, 1);
      bus.rearm_req = 1'b0;
      step();
      chk("s1_ack_once", bus.rearm_ack, 0);
      // scenario 2: veto drop cuts power combinationally and latches a trip
      bus.veto_enable_in = 1'b0;
      #1;
      chk("s2_cut_now", bus.motor_power_en, 0);
      step();
      chk("s2_tripped", bus.state_o, 1);
      chk("s2_trip_pulse", bus.trip_pulse, 1);
      chk("s2_count", bus.trip_count, 1);
      bus.veto_enable_in = 1'b1;
      bus.rearm_req = 1'b1;
      #1;
      chk("s2_power_latched", bus.motor_power_en, 0);
      // scenario 3: request held high throughout; exact dwell and no ack
      step();
      chk("s3_trip_once", bus.trip_pulse, 0);
      step(2);
      chk("s3_still_tripped", bus.state_o, 1);
      chk("s3_no_ack_t", bus.rearm_ack, 0);
      step();
      chk("s3_clearing", bus.state_o, 2);
      step(2);
      chk("s3_still_clearing", bus.state_o, 2);
      step();
      chk("s3_ready", bus.state_o, 3);
      step();
      chk("s3_held_no_ack", bus.rearm_ack, 0);
      chk("s3_held_ready", bus.state_o, 3);
      bus.rearm_req = 1'b0;
      step();
      bus.rearm_req = 1'b1;
      step();
      chk("s3_new_edge_ack", bus.rearm_ack, 1);
      chk("s3_armed", bus.state_o, 0);
      chk("s3_count", bus.trip_count, 1);
      // scenario 4: presence during clearing restarts the count
      bus.rearm_req = 1'b0;
      bus.veto_enable_in = 1'b0;
      step();
      chk("s4_count", bus.trip_count, 2);
      bus.veto_enable_in = 1'b1;
      step(4);
      chk("s4_clearing", bus.state_o, 2);
      step(2);
      bus.human_presence_sensor = 1'b1;
      step();
      chk("s4_reset_count", bus.state_o, 2);
      bus.human_presence_sensor = 1'b0;
      step(2);
      chk("s4_not_yet", bus.state_o, 2);
      step();
      chk("s4_ready", bus.state_o, 3);
      // scenario 5: presence outranks a simultaneous request edge
      bus.human_presence_sensor = 1'b1;
      bus.rearm_req = 1'b1;
      step();
      chk("s5_state", bus.state_o, 2);
      chk("s5_no_ack", bus.rearm_ack, 0);
      chk("s5_power", bus.motor_power_en, 0);
      bus.human_presence_sensor = 1'b0;
      bus.rearm_req = 1'b0;
      step(3);
      chk("s5_ready_again", bus.state_o, 3);
      // scenario 6a: asynchronous reset in the middle of TRIPPED
      bus.rearm_req = 1'b1;
      step();
      bus.rearm_req = 1'b0;
      bus.veto_enable_in = 1'b0;
      step();
      chk("s6_count3", bus.trip_count, 3);
      bus.veto_enable_in = 1'b1;
      step();
      rst_n = 1'b0;
      #1;
      chk("s6_rst_state", bus.state_o, 2);
      chk("s6_rst_count", bus.trip_count, 0);
      chk("s6_rst_power", bus.motor_power_en, 0);
      chk("s6_rst_trip", bus.trip_pulse, 0);
      step();
      rst_n = 1'b1;
      // scenario 6b: five trips on a 2-bit counter saturate at 3
      for (int i = 0; i < 5; i++) begin
         step(3);
         chk("s6_loop_ready", bus.state_o, 3);
         bus.rearm_req = 1'b1;
         step();
         chk("s6_loop_ack", bus.rearm_ack, 1);
         bus.rearm_req = 1'b0;
         bus.veto_enable_in = 1'b0;
         step();
         chk("s6_sat_count", bus.trip_count, (i + 1 > 3) ? 3 : i + 1);
         bus.veto_enable_in = 1'b1;
         step(4);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
